// File: rtl/l1_d_pkg.sv
// l1_d_pkg: default geometry, derived widths, FSM state type and parity helper shared by the
// set-associative L1 D data array and its way sub-module.
package l1_d_pkg;

  localparam int NUM_WAYS   = 2;
  localparam int NUM_SETS   = 64;
  localparam int BLOCK_BITS = 512;
  localparam int WORD_BITS  = 32;
  localparam int BEAT_BITS  = 128;

  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int OFFSET_W   = $clog2(BLOCK_BITS / 8);
  localparam int NBEATS     = BLOCK_BITS / BEAT_BITS;
  localparam int BEAT_CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  // Widest word the parity helper accepts; narrower words are zero-extended by the caller.
  localparam int MAX_WORD_BITS = 128;

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

  function automatic logic even_parity(input logic [MAX_WORD_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/l1_d_data_way.sv
// l1_d_data_way: one way of the L1 D data array -- NUM_SETS blocks with a refill beat write port,
// a byte-masked word store port and a registered block read. PARITY_EN adds one parity bit per word.
module l1_d_data_way #(
  parameter int  NUM_SETS   = l1_d_pkg::NUM_SETS,
  parameter int  BLOCK_BITS = l1_d_pkg::BLOCK_BITS,
  parameter int  WORD_BITS  = l1_d_pkg::WORD_BITS,
  parameter int  BEAT_BITS  = l1_d_pkg::BEAT_BITS,
  localparam int INDEX_W    = $clog2(NUM_SETS),
  localparam int NBEATS     = BLOCK_BITS / BEAT_BITS,
  localparam int BEAT_CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  localparam int NWORDS     = BLOCK_BITS / WORD_BITS,
  localparam int WORD_SEL_W = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                   clk_i,
  input  logic                   nrst_i,
  input  logic [INDEX_W-1:0]     index_i,
  input  logic                   rd_en_i,
  output logic [BLOCK_BITS-1:0]  rd_data_o,
`ifdef PARITY_EN
  output logic                   rd_par_err_o,
`endif
  input  logic                   beat_we_i,
  input  logic [BEAT_CNT_W-1:0]  beat_sel_i,
  input  logic [BEAT_BITS-1:0]   beat_data_i,
  input  logic                   word_we_i,
  input  logic [WORD_SEL_W-1:0]  word_sel_i,
  input  logic [WORD_BITS-1:0]   word_data_i,
  input  logic [WORD_BITS/8-1:0] byte_en_i
);
  import l1_d_pkg::*;

  logic [BLOCK_BITS-1:0] mem_q [NUM_SETS];
  logic [BLOCK_BITS-1:0] rdData_q;
  logic [WORD_BITS-1:0]  mergedWord;

  // Store merges the enabled bytes into the current word so the array only needs word writes.
  always_comb begin
    mergedWord = mem_q[index_i][word_sel_i*WORD_BITS +: WORD_BITS];
    for (int b = 0; b < WORD_BITS / 8; b++) begin
      if (byte_en_i[b +: 1] == 1'b1) begin
        mergedWord[b*8 +: 8] = word_data_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (beat_we_i) begin
      mem_q[index_i][beat_sel_i*BEAT_BITS +: BEAT_BITS] <= beat_data_i;
    end else if (word_we_i) begin
      mem_q[index_i][word_sel_i*WORD_BITS +: WORD_BITS] <= mergedWord;
    end
  end

  // Sampling mem_q before the same-edge write gives read-before-write ordering.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      rdData_q <= '0;
    end else if (rd_en_i) begin
      rdData_q <= mem_q[index_i];
    end
  end

  assign rd_data_o = rdData_q;

`ifdef PARITY_EN
  localparam int WORDS_PER_BEAT = BEAT_BITS / WORD_BITS;

  logic [NWORDS-1:0]     par_q [NUM_SETS];
  logic [BLOCK_BITS-1:0] rdBlock;
  logic [NWORDS-1:0]     rdPar;
  logic                  parErr;
  logic                  rdParErr_q;

  always_ff @(posedge clk_i) begin
    if (beat_we_i) begin
      for (int w = 0; w < WORDS_PER_BEAT; w++) begin
        par_q[index_i][beat_sel_i*WORDS_PER_BEAT + w +: 1] <=
          even_parity(MAX_WORD_BITS'(beat_data_i[w*WORD_BITS +: WORD_BITS]));
      end
    end else if (word_we_i) begin
      par_q[index_i][word_sel_i +: 1] <= even_parity(MAX_WORD_BITS'(mergedWord));
    end
  end

  always_comb begin
    rdBlock = mem_q[index_i];
    rdPar   = par_q[index_i];
    parErr  = 1'b0;
    for (int w = 0; w < NWORDS; w++) begin
      if (even_parity(MAX_WORD_BITS'(rdBlock[w*WORD_BITS +: WORD_BITS])) != rdPar[w +: 1]) begin
        parErr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      rdParErr_q <= 1'b0;
    end else if (rd_en_i) begin
      rdParErr_q <= parErr;
    end
  end

  assign rd_par_err_o = rdParErr_q;
`endif

endmodule

// File: rtl/l1_d_data_array_assoc.sv
// l1_d_data_array_assoc: NUM_WAYS-way L1 D data array with registered reads, byte-enabled stores
// and multi-beat L2 refills. Define PARITY_EN to add per-word parity and the rd_parity_err output.
module l1_d_data_array_assoc #(
  parameter int  NUM_WAYS   = l1_d_pkg::NUM_WAYS,
  parameter int  NUM_SETS   = l1_d_pkg::NUM_SETS,
  parameter int  BLOCK_BITS = l1_d_pkg::BLOCK_BITS,
  parameter int  WORD_BITS  = l1_d_pkg::WORD_BITS,
  parameter int  BEAT_BITS  = l1_d_pkg::BEAT_BITS,
  localparam int INDEX_W    = $clog2(NUM_SETS),
  localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int OFFSET_W   = $clog2(BLOCK_BITS / 8),
  localparam int BYTES_W    = WORD_BITS / 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [INDEX_W-1:0]    index,
  input  logic [WAY_W-1:0]      way,
  input  logic [OFFSET_W-1:0]   offset,
  input  logic                  rd_en,
  output logic [BLOCK_BITS-1:0] read_data,
  output logic                  rd_valid,
`ifdef PARITY_EN
  output logic                  rd_parity_err,
`endif
  input  logic                  update_L1,
  input  logic [WORD_BITS-1:0]  write_data,
  input  logic [BYTES_W-1:0]    byte_en,
  input  logic                  refill_L1,
  input  logic                  l2_valid,
  output logic                  l2_ready,
  input  logic [BEAT_BITS-1:0]  data_block_L2,
  output logic                  refill_done,
  output logic                  stall_L1
);
  import l1_d_pkg::*;

  localparam int NBEATS     = BLOCK_BITS / BEAT_BITS;
  localparam int BEAT_CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int WORD_OFF_W = $clog2(BYTES_W);
  localparam int WORD_SEL_W = OFFSET_W - WORD_OFF_W;

  state_e                state_q, state_d;
  logic [INDEX_W-1:0]    refIndex_q;
  logic [WAY_W-1:0]      refWay_q;
  logic [BEAT_CNT_W-1:0] beatCnt_q;
  logic [WAY_W-1:0]      rdWay_q;
  logic                  rdValid_q;
  logic                  refillDone_q;

  logic                  rdAccept;
  logic                  wrAccept;
  logic                  beatFire;
  logic                  lastBeat;
  logic [INDEX_W-1:0]    accIndex;
  logic [WORD_SEL_W-1:0] wordSel;
  logic                  unusedOffsetLsb;
  logic [BLOCK_BITS-1:0] wayRdData [NUM_WAYS];

  assign rdAccept        = rd_en & ~stall_L1;
  assign wrAccept        = update_L1 & ~stall_L1;
  assign beatFire        = l2_valid & l2_ready;
  assign lastBeat        = (beatCnt_q == BEAT_CNT_W'(NBEATS - 1));
  assign accIndex        = (state_q == REFILL) ? refIndex_q : index;
  assign wordSel         = offset[OFFSET_W-1 -: WORD_SEL_W];
  assign unusedOffsetLsb = ^offset[WORD_OFF_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (refill_L1) state_d = REFILL;
      REFILL:  if (beatFire && lastBeat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // stall_L1 covers the refill-start cycle too, so requests arriving with refill_L1 are dropped.
  always_comb begin
    l2_ready = 1'b0;
    stall_L1 = 1'b0;
    unique case (state_q)
      IDLE:    stall_L1 = refill_L1;
      REFILL: begin
        l2_ready = 1'b1;
        stall_L1 = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      refIndex_q   <= '0;
      refWay_q     <= '0;
      beatCnt_q    <= '0;
      rdWay_q      <= '0;
      rdValid_q    <= 1'b0;
      refillDone_q <= 1'b0;
    end else begin
      rdValid_q    <= rdAccept;
      refillDone_q <= beatFire & lastBeat;
      if (rdAccept) begin
        rdWay_q <= way;
      end
      if (state_q == IDLE && refill_L1) begin
        refIndex_q <= index;
        refWay_q   <= way;
        beatCnt_q  <= '0;
      end else if (beatFire) begin
        beatCnt_q <= beatCnt_q + BEAT_CNT_W'(1);
      end
    end
  end

  assign rd_valid    = rdValid_q;
  assign refill_done = refillDone_q;
  assign read_data   = wayRdData[rdWay_q];

`ifdef PARITY_EN
  logic [NUM_WAYS-1:0] wayPerr;
  assign rd_parity_err = wayPerr[rdWay_q];
`endif

  for (genvar g = 0; g < NUM_WAYS; g++) begin : gWay
    logic reqHit;
    logic refHit;
    assign reqHit = (way == WAY_W'(g));
    assign refHit = (refWay_q == WAY_W'(g));

    l1_d_data_way #(
      .NUM_SETS  (NUM_SETS),
      .BLOCK_BITS(BLOCK_BITS),
      .WORD_BITS (WORD_BITS),
      .BEAT_BITS (BEAT_BITS)
    ) uWay (
      .clk_i       (clk),
      .nrst_i      (nrst),
      .index_i     (accIndex),
      .rd_en_i     (rdAccept & reqHit),
      .rd_data_o   (wayRdData[g]),
`ifdef PARITY_EN
      .rd_par_err_o(wayPerr[g]),
`endif
      .beat_we_i   (beatFire & refHit),
      .beat_sel_i  (beatCnt_q),
      .beat_data_i (data_block_L2),
      .word_we_i   (wrAccept & reqHit),
      .word_sel_i  (wordSel),
      .word_data_i (write_data),
      .byte_en_i   (byte_en)
    );
  end

endmodule

// File: tb/tb_l1_d_data_array_assoc.sv
// Scoreboard bench for l1_d_data_array_assoc: a block-granular array model predicts every read and a
// negedge monitor retires predictions as rd_valid pulses arrive. Build with PARITY_EN defined for parity.
module tb_l1_d_data_array_assoc;

  localparam int NumWays   = 2;
  localparam int NumSets   = 64;
  localparam int BlockBits = 512;
  localparam int WordBits  = 32;
  localparam int BeatBits  = 128;
  localparam int NBeats    = BlockBits / BeatBits;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic [5:0]           index;
  logic [0:0]           way;
  logic [5:0]           offset;
  logic                 rd_en;
  logic [BlockBits-1:0] read_data;
  logic                 rd_valid;
`ifdef PARITY_EN
  logic                 rd_parity_err;
`endif
  logic                 update_L1;
  logic [WordBits-1:0]  write_data;
  logic [3:0]           byte_en;
  logic                 refill_L1;
  logic                 l2_valid;
  logic                 l2_ready;
  logic [BeatBits-1:0]  data_block_L2;
  logic                 refill_done;
  logic                 stall_L1;

  typedef struct {
    logic [BlockBits-1:0] data;
    logic                 perr;
    int                   due;
  } rdExp_t;

  logic [BlockBits-1:0] model [NumWays][NumSets];
  logic                 corrupt [NumWays][NumSets];
  rdExp_t               expQ[$];
  rdExp_t               monE;
  logic [BlockBits-1:0] holdExp;
  int                   cyc = 0;
  int                   vecs = 0;
  int                   miscompares = 0;

  l1_d_data_array_assoc dut (
    .clk          (clk),
    .nrst         (nrst),
    .index        (index),
    .way          (way),
    .offset       (offset),
    .rd_en        (rd_en),
    .read_data    (read_data),
    .rd_valid     (rd_valid),
`ifdef PARITY_EN
    .rd_parity_err(rd_parity_err),
`endif
    .update_L1    (update_L1),
    .write_data   (write_data),
    .byte_en      (byte_en),
    .refill_L1    (refill_L1),
    .l2_valid     (l2_valid),
    .l2_ready     (l2_ready),
    .data_block_L2(data_block_L2),
    .refill_done  (refill_done),
    .stall_L1     (stall_L1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [BlockBits-1:0] act,
                             input logic [BlockBits-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [BlockBits-1:0] randBlock();
    logic [BlockBits-1:0] b;
    for (int i = 0; i < BlockBits / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic idleInputs();
    rd_en = 1'b0; update_L1 = 1'b0; refill_L1 = 1'b0; l2_valid = 1'b0;
  endtask

  // Monitor: retires one prediction per rd_valid pulse; otherwise read_data must hold its last value.
  always @(negedge clk) begin
    if (nrst) begin
      if (rd_valid) begin
        if (expQ.size() == 0) begin
          vecs++;
          miscompares++;
          $display("[TB] FAIL rd_valid: got unexpected pulse, expected none");
        end else begin
          monE = expQ.pop_front();
          checkInt("rd_latency", cyc, monE.due);
          checkOutput("read_data", read_data, monE.data);
`ifdef PARITY_EN
          checkFlag("rd_parity_err", rd_parity_err, monE.perr);
`endif
          holdExp = monE.data;
        end
      end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
        vecs++;
        miscompares++;
        $display("[TB] FAIL rd_valid: got no pulse at cycle %0d, expected one", cyc);
        void'(expQ.pop_front());
      end else begin
        checkOutput("read_hold", read_data, holdExp);
      end
    end
  end

  // One IDLE-state cycle; the model applies accepted reads/stores, a refill start blocks both.
  task automatic applyStimulus(input logic rd, input logic upd, input logic rf, input int w,
                               input int s, input logic [5:0] off, input logic [31:0] wd,
                               input logic [3:0] be);
    rdExp_t e;
    rd_en = rd; update_L1 = upd; refill_L1 = rf; l2_valid = 1'b0;
    way = 1'(w); index = 6'(s); offset = off; write_data = wd; byte_en = be;
    #1;
    checkFlag("stall_idle", stall_L1, rf);
    if (!rf) begin
      if (rd) begin
        e.data = model[w][s];
        e.perr = corrupt[w][s];
        e.due  = cyc + 1;
        expQ.push_back(e);
      end
      if (upd) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[w][s][int'(off[5:2])*32 + b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    @(posedge clk); #1;
    idleInputs();
  endtask

  task automatic refillBlock(input int w, input int s, input logic [BlockBits-1:0] blk,
                             input int gap, input logic withStore, input int abortAfter);
    applyStimulus(1'b0, withStore, 1'b1, w, s, 6'd0, $urandom, 4'hF);
    corrupt[w][s] = 1'b0;
    for (int bt = 0; bt < NBeats; bt++) begin
      if (abortAfter == bt) begin
        nrst = 1'b0;
        holdExp = '0;
        #1;
        checkFlag("abort_stall", stall_L1, 1'b0);
        checkFlag("abort_l2_ready", l2_ready, 1'b0);
        checkFlag("abort_rd_valid", rd_valid, 1'b0);
        checkFlag("abort_refill_done", refill_done, 1'b0);
        checkOutput("abort_read_data", read_data, '0);
        #6;
        nrst = 1'b1;
        @(posedge clk); #1;
        return;
      end
      for (int g = 0; g < gap; g++) begin
        l2_valid = 1'b0; rd_en = 1'b1; update_L1 = 1'b1; refill_L1 = 1'b1;
        way = 1'($urandom); index = 6'($urandom); offset = 6'($urandom);
        write_data = $urandom; byte_en = 4'hF;
        #1;
        checkFlag("gap_stall", stall_L1, 1'b1);
        checkFlag("gap_l2_ready", l2_ready, 1'b1);
        @(posedge clk); #1;
      end
      rd_en = 1'b0; update_L1 = 1'b0; refill_L1 = 1'b0;
      l2_valid = 1'b1;
      data_block_L2 = blk[bt*BeatBits +: BeatBits];
      #1;
      checkFlag("beat_l2_ready", l2_ready, 1'b1);
      checkFlag("beat_stall", stall_L1, 1'b1);
      checkFlag("early_done", refill_done, 1'b0);
      model[w][s][bt*BeatBits +: BeatBits] = blk[bt*BeatBits +: BeatBits];
      @(posedge clk); #1;
      l2_valid = 1'b0;
    end
    checkFlag("refill_done", refill_done, 1'b1);
    checkFlag("post_stall", stall_L1, 1'b0);
  endtask

  initial begin
    logic [BlockBits-1:0] blk;
    int r;
    nrst = 1'b0;
    idleInputs();
    index = '0; way = '0; offset = '0; write_data = '0; byte_en = '0; data_block_L2 = '0;
    holdExp = '0;
    for (int w = 0; w < NumWays; w++)
      for (int s = 0; s < NumSets; s++) corrupt[w][s] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkFlag("reset_rd_valid", rd_valid, 1'b0);
    checkOutput("reset_read_data", read_data, '0);
    checkFlag("reset_l2_ready", l2_ready, 1'b0);
    checkFlag("reset_refill_done", refill_done, 1'b0);
    checkFlag("reset_stall", stall_L1, 1'b0);
    refill_L1 = 1'b1;
    #1;
    checkFlag("reset_stall_comb", stall_L1, 1'b1);
    refill_L1 = 1'b0;
    nrst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] filling every block");
    for (int w = 0; w < NumWays; w++)
      for (int s = 0; s < NumSets; s++) refillBlock(w, s, randBlock(), 0, 1'b0, -1);

    $display("[TB] directed cases");
    blk = {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}};
    refillBlock(1, 5, blk, 0, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 5, 6'd0, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 6'd0, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 5, 6'd8, 32'hDEADBEEF, 4'b0101);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 5, 6'd0, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 5, 6'd20, 32'hCAFEF00D, 4'b0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1, 5, 6'd12, 32'h12345678, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 5, 6'd0, 32'h0, 4'h0);

    refillBlock(0, 7, randBlock(), 0, 1'b1, -1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 7, 6'd0, 32'h0, 4'h0);
    refillBlock(1, 4, randBlock(), 0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 4, 6'd0, 32'h0, 4'h0);
    refillBlock(1, 9, randBlock(), 3, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 9, 6'd0, 32'h0, 4'h0);
    refillBlock(0, 3, randBlock(), 0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 3, 6'd0, 32'h0, 4'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        refillBlock($urandom_range(0, 1), $urandom_range(0, 3), randBlock(),
                    $urandom_range(0, 2), 1'($urandom), -1);
      end else begin
        applyStimulus(1'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 1),
                      $urandom_range(0, 3), 6'($urandom), $urandom, 4'($urandom));
      end
    end
    for (int w = 0; w < NumWays; w++)
      for (int s = 0; s < 4; s++) applyStimulus(1'b1, 1'b0, 1'b0, w, s, 6'd0, 32'h0, 4'h0);

`ifdef PARITY_EN
    $display("[TB] parity cases");
    model[1][5][7] = ~model[1][5][7];
    dut.gWay[1].uWay.mem_q[5][7] = ~dut.gWay[1].uWay.mem_q[5][7];
    corrupt[1][5] = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 5, 6'd0, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 5, 6'd0, 32'h0, 4'h0);
    refillBlock(1, 5, randBlock(), 0, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 5, 6'd0, 32'h0, 4'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkInt("pending_reads", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected finish", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/l1_d_data_array_assoc.md
Name: l1_d_data_array_assoc

Overview:
Parametrised set-associative successor to the L1 data-cache data array. Stores NUM_WAYS blocks per set. Supplies registered block reads. Accepts byte-enabled word stores from the LSU. Performs multi-beat block refills from L2 over a valid/ready stream, holding stall_L1 high while a refill is in progress. Sits between the L1 D tag/control logic and the L2 refill path.

Parameters:
NUM_WAYS, 2, associativity (power of 2, >=1)
NUM_SETS, 64, sets per way (power of 2)
BLOCK_BITS, 512, cache block width
WORD_BITS, 32, store word width
BEAT_BITS, 128, L2 refill beat width; BLOCK_BITS/BEAT_BITS = NBEATS >= 1

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
index  in  log2(NUM_SETS)  set for read/update/refill
way  in  max(1,log2(NUM_WAYS))  way for read/update/refill
offset  in  log2(BLOCK_BITS/8)  byte offset in block; word = offset[MSB:log2(WORD_BITS/8)], low bits ignored
rd_en  in  1  read request
read_data  out  BLOCK_BITS  registered block read
rd_valid  out  1  read_data valid, one-cycle pulse
update_L1  in  1  store word write_data at way/index/offset
write_data  in  WORD_BITS  store data
byte_en  in  WORD_BITS/8  store byte enables
refill_L1  in  1  start refill of way/index
l2_valid  in  1  L2 beat valid
l2_ready  out  1  array accepts beat
data_block_L2  in  BEAT_BITS  refill beat, beat 0 = block LSBs
refill_done  out  1  one-cycle pulse on last beat write
stall_L1  out  1  array busy

Behaviour:
- Reset (async, nrst=0): state IDLE; beat_cnt=0; read_data=0; rd_valid=0; l2_ready=0; refill_done=0. Storage is not reset.
- FSM states: IDLE, REFILL.
- IDLE, refill_L1=1: latch index and way, beat_cnt=0, go to REFILL. A concurrent rd_en or update_L1 in that cycle is ignored.
- REFILL: l2_ready=1. On l2_valid&&l2_ready, write the beat at bits [beat_cnt*BEAT_BITS +: BEAT_BITS] of the latched set/way, then increment beat_cnt.
- Last beat (beat_cnt==NBEATS-1): refill_done=1 in the cycle after the write; return to IDLE.
- l2_valid low holds state; no timeout.
- stall_L1 = (state==REFILL) | (state==IDLE & refill_L1). This is combinational.
- Read: rd_en=1 with stall_L1=0 gives read_data/rd_valid at the next edge (1-cycle latency). read_data holds its value until the next accepted read.
- Store: update_L1=1 with stall_L1=0 writes the enabled bytes of the selected word at the edge. byte_en=0 produces no change.
- Read and update to the same set/way in one cycle: the read returns pre-write data (read-before-write).
- rd_en/update_L1 asserted while stall_L1=1 are dropped. The requester holds the request until stall_L1 falls.
- refill_L1 in REFILL is ignored.
- Reset during REFILL: return to IDLE immediately. Beats already written stay; the rest of the block is stale.

Optional Feature:
PARITY_EN. When defined:
- One even-parity bit is stored per WORD_BITS word. It is recomputed on store (full word after merge) and on refill.
- Extra output rd_parity_err (1 bit) is registered alongside rd_valid. It is high if any word of the read block mismatches its parity.
- rd_parity_err resets to 0.
When undefined: no parity storage and no port.

Decomposition:
- Shared package l1_d_pkg: derived widths (INDEX_W, WAY_W, OFFSET_W, NBEATS, BEAT_CNT_W), state enum {IDLE, REFILL}, parity function.
- One sub-module, l1_d_data_way: a single-way NUM_SETS x BLOCK_BITS array with a beat write port, a byte-masked word write port and a registered read.
- The top module instantiates NUM_WAYS copies of l1_d_data_way plus the FSM and output mux.

Test Plan:
- Refill way1/set5 with beats 0x11..,0x22..,0x33..,0x44.. (NBEATS=4), then rd_en → refill_done one cycle after beat 3; read_data = {0x44..,0x33..,0x22..,0x11..} with rd_valid one cycle after rd_en.
- Store 0xDEADBEEF, byte_en=4'b0101, offset=8 to the refilled block, then read → word 2 bytes 0 and 2 updated, bytes 1 and 3 unchanged, other words unchanged.
- refill_L1 and update_L1 in the same IDLE cycle → stall_L1=1 that cycle; the store is not written.
- l2_valid gapped by 3 idle cycles between beats → beat_cnt holds; stall_L1 stays 1; block is correct after refill_done.
- nrst low after 2 of 4 beats → outputs reset, stall_L1=0; a read shows beats 0-1 new and beats 2-3 old.
- PARITY_EN defined: force-corrupt one stored bit, read → rd_parity_err=1; a clean read gives rd_parity_err=0.
